mc_comp: RTL and testbench

Multicycle 32-bit MIPS-subset computer: controller FSM, datapath, 32×32 register file and one unified instruction/data memory in a single top level. It is the top of the multicycle CPU simulation build. The bench preloads program and data straight into memory, runs the clock, and reads any architectural register through a debug port.

---
 rtl/mc_comp.sv | 187 ++++++++++++++++++
 tb/tb_mc_comp.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mc_comp.sv
// Multicycle MIPS-subset computer: controller FSM, datapath, register file and
// one unified instruction/data memory shared between fetch and load/store.

module mc_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [6:0]  idx,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] dmem [0:127];

  assign rd = dmem[idx];

  always_ff @(posedge clk) begin
    if (we) dmem[idx] <= wd;
  end
endmodule

module mc_comp (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  state_t      r_state;
  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] r_a, r_b, r_aluout, r_mdr;
  logic [31:0] r_rf [0:31];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dst;
  logic [31:0] w_sext, w_zext, w_rs_val, w_rt_val, w_alu, w_mrd;
  logic signed [31:0] w_sa, w_sb, w_simm;
  logic        w_is_r_alu, w_is_i_alu, w_is_jr, w_is_j, w_is_jal;
  logic        w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_we, w_taken;
  logic [6:0]  w_midx;

  assign w_op     = instr[31:26];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_shamt  = instr[10:6];
  assign w_funct  = instr[5:0];
  assign w_sext   = {{16{instr[15]}}, instr[15:0]};
  assign w_zext   = {16'h0000, instr[15:0]};
  assign w_sa     = r_a;
  assign w_sb     = r_b;
  assign w_simm   = w_sext;

  // r_rf[0] is never written, so plain indexing already reads r0 as zero.
  assign w_rs_val = r_rf[w_rs];
  assign w_rt_val = r_rf[w_rt];

  always_comb begin
    w_is_r_alu = 1'b0;
    if (w_op == 6'h00) begin
      case (w_funct)
        6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: w_is_r_alu = 1'b1;
        default: w_is_r_alu = 1'b0;
      endcase
    end
  end

  assign w_is_jr    = (w_op == 6'h00) && (w_funct == 6'h08);
  assign w_is_i_alu = (w_op == 6'h08) || (w_op == 6'h09) || (w_op == 6'h0C) ||
                      (w_op == 6'h0D) || (w_op == 6'h0F) || (w_op == 6'h0A);
  assign w_is_lw    = (w_op == 6'h23);
  assign w_is_sw    = (w_op == 6'h2B);
  assign w_is_beq   = (w_op == 6'h04);
  assign w_is_bne   = (w_op == 6'h05);
  assign w_is_j     = (w_op == 6'h02);
  assign w_is_jal   = (w_op == 6'h03);
  assign w_taken    = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
  assign w_dst      = (w_op == 6'h00) ? w_rd : w_rt;

  always_comb begin
    w_alu = '0;
    if (w_op == 6'h00) begin
      case (w_funct)
        6'h21:   w_alu = r_a + r_b;
        6'h23:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = {31'd0, (w_sa < w_sb)};
        6'h00:   w_alu = r_b << w_shamt;
        6'h02:   w_alu = r_b >> w_shamt;
        default: w_alu = '0;
      endcase
    end else begin
      case (w_op)
        6'h08, 6'h09: w_alu = r_a + w_sext;
        6'h0C:        w_alu = r_a & w_zext;
        6'h0D:        w_alu = r_a | w_zext;
        6'h0F:        w_alu = {instr[15:0], 16'h0000};
        6'h0A:        w_alu = {31'd0, (w_sa < w_simm)};
        default:      w_alu = '0;
      endcase
    end
  end

  // Fetch owns the memory port in IF; every other state addresses it via ALUOut.
  assign w_midx = (r_state == S_IF) ? PC[8:2] : r_aluout[8:2];
  assign w_we   = (r_state == S_MEM) && w_is_sw;

  mc_mem U_DM (
    .clk (clk),
    .we  (w_we),
    .idx (w_midx),
    .wd  (r_b),
    .rd  (w_mrd)
  );

  always_comb begin
    reg_data = '0;
    for (int i = 1; i < 32; i++) begin
      if (reg_sel == 5'(i)) reg_data = r_rf[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IF;
      PC       <= '0;
      instr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_IF: begin
          instr   <= w_mrd;
          PC      <= PC + 32'd4;
          r_state <= S_ID;
        end
        S_ID: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          r_aluout <= PC + (w_sext << 2);
          if (w_is_j || w_is_jal) begin
            PC <= {PC[31:28], instr[25:0], 2'b00};
            if (w_is_jal) r_rf[31] <= PC;
            r_state <= S_IF;
          end else if (w_is_jr) begin
            PC      <= w_rs_val;
            r_state <= S_IF;
          end else if (w_is_r_alu || w_is_i_alu || w_is_lw || w_is_sw ||
                       w_is_beq || w_is_bne) begin
            r_state <= S_EX;
          end else begin
            r_state <= S_IF;
          end
        end
        S_EX: begin
          if (w_is_lw || w_is_sw) begin
            r_aluout <= r_a + w_sext;
            r_state  <= S_MEM;
          end else if (w_is_beq || w_is_bne) begin
            if (w_taken) PC <= r_aluout;
            r_state <= S_IF;
          end else begin
            r_aluout <= w_alu;
            r_state  <= S_WB;
          end
        end
        S_MEM: begin
          if (w_is_lw) begin
            r_mdr   <= w_mrd;
            r_state <= S_WB;
          end else begin
            r_state <= S_IF;
          end
        end
        S_WB: begin
          if (w_dst != 5'd0) r_rf[w_dst] <= w_is_lw ? r_mdr : r_aluout;
          r_state <= S_IF;
        end
        default: r_state <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_comp.sv
// Directed program bench for mc_comp: loads a small MIPS program, steps the
// clock to known instruction boundaries and checks architectural state.

module tb_mc_comp;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;

  mc_comp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #50 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [4:0] sel, input logic [31:0] exp, input string tag);
    reg_sel = sel;
    #1;
    check(tag, reg_data, exp);
  endtask

  task automatic adv_to(input int k);
    while (ecount < k) begin
      @(posedge clk);
      ecount++;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) dut.U_DM.dmem[i] = 32'h0;
    dut.U_DM.dmem[0]  = enc_i(6'h0F, 5'd0, 5'd1, 16'h8000);        // lui  $1,0x8000
    dut.U_DM.dmem[1]  = enc_r(5'd0, 5'd1, 5'd7, 5'd4, 6'h02);      // srl  $7,$1,4
    dut.U_DM.dmem[2]  = enc_r(5'd0, 5'd1, 5'd8, 5'd1, 6'h00);      // sll  $8,$1,1
    dut.U_DM.dmem[3]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFB);        // addi $2,$0,-5
    dut.U_DM.dmem[4]  = enc_i(6'h08, 5'd0, 5'd3, 16'h0003);        // addi $3,$0,3
    dut.U_DM.dmem[5]  = enc_r(5'd2, 5'd3, 5'd4, 5'd0, 6'h2A);      // slt  $4,$2,$3
    dut.U_DM.dmem[6]  = enc_r(5'd3, 5'd2, 5'd5, 5'd0, 6'h23);      // subu $5,$3,$2
    dut.U_DM.dmem[7]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0100);        // sw   $5,0x100($0)
    dut.U_DM.dmem[8]  = enc_i(6'h23, 5'd0, 5'd6, 16'h0100);        // lw   $6,0x100($0)
    dut.U_DM.dmem[9]  = enc_i(6'h04, 5'd0, 5'd0, 16'h0001);        // beq  taken -> 11
    dut.U_DM.dmem[10] = enc_i(6'h08, 5'd0, 5'd9, 16'h0001);        // addi $9 (skipped)
    dut.U_DM.dmem[11] = enc_i(6'h05, 5'd0, 5'd0, 16'h0001);        // bne  not taken
    dut.U_DM.dmem[12] = enc_i(6'h08, 5'd0, 5'd10, 16'h0007);       // addi $10,$0,7
    dut.U_DM.dmem[13] = enc_i(6'h08, 5'd0, 5'd0, 16'h0005);        // addi $0,$0,5
    dut.U_DM.dmem[14] = 32'hFC00_0000;                             // unknown opcode
    dut.U_DM.dmem[15] = enc_j(6'h03, 26'd21);                      // jal  21
    dut.U_DM.dmem[16] = enc_i(6'h0D, 5'd0, 5'd11, 16'h1234);       // ori  $11,$0,0x1234
    dut.U_DM.dmem[17] = enc_r(5'd11, 5'd3, 5'd13, 5'd0, 6'h25);    // or   $13,$11,$3
    dut.U_DM.dmem[18] = enc_r(5'd13, 5'd3, 5'd12, 5'd0, 6'h24);    // and  $12,$13,$3
    dut.U_DM.dmem[19] = enc_i(6'h0A, 5'd2, 5'd14, 16'hFFFC);       // slti $14,$2,-4
    dut.U_DM.dmem[20] = enc_j(6'h02, 26'd20);                      // j    self
    dut.U_DM.dmem[21] = enc_i(6'h09, 5'd0, 5'd15, 16'd100);        // addiu $15,$0,100
    dut.U_DM.dmem[22] = enc_r(5'd15, 5'd3, 5'd16, 5'd0, 6'h21);    // addu $16,$15,$3
    dut.U_DM.dmem[23] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);     // jr   $31

    #20;
    check("rst_pc", dut.PC, 32'h0);
    check("rst_instr", dut.instr, 32'h0);
    chk_reg(5'd0, 32'h0, "rst_r0");
    chk_reg(5'd1, 32'h0, "rst_r1");
    chk_reg(5'd31, 32'h0, "rst_r31");
    rstn = 1'b1;

    adv_to(1);
    check("if_pc", dut.PC, 32'h4);
    check("if_instr", dut.instr, 32'h3C01_8000);
    adv_to(3);
    chk_reg(5'd1, 32'h0, "lui_before_wb");
    adv_to(4);
    chk_reg(5'd1, 32'h8000_0000, "lui_r1");
    adv_to(8);
    chk_reg(5'd7, 32'h0800_0000, "srl_r7");
    adv_to(12);
    chk_reg(5'd8, 32'h0, "sll_r8");

    adv_to(36);
    check("sw_mem", dut.U_DM.dmem[64], 32'h8);
    chk_reg(5'd6, 32'h0, "lw_before_wb");
    adv_to(37);
    chk_reg(5'd6, 32'h8, "lw_r6");

    adv_to(53);
    check("nop_pc", dut.PC, 32'd60);
    adv_to(55);
    check("jal_pc", dut.PC, 32'd84);
    chk_reg(5'd31, 32'd64, "jal_r31");
    adv_to(65);
    check("jr_pc", dut.PC, 32'd64);

    adv_to(101);
    check("loop_pc", dut.PC, 32'd80);
    chk_reg(5'd0, 32'h0, "r0");
    chk_reg(5'd1, 32'h8000_0000, "r1");
    chk_reg(5'd2, 32'hFFFF_FFFB, "r2");
    chk_reg(5'd3, 32'h3, "r3");
    chk_reg(5'd4, 32'h1, "slt_r4");
    chk_reg(5'd5, 32'h8, "subu_r5");
    chk_reg(5'd9, 32'h0, "beq_skip_r9");
    chk_reg(5'd10, 32'h7, "bne_fall_r10");
    chk_reg(5'd11, 32'h1234, "ori_r11");
    chk_reg(5'd12, 32'h3, "and_r12");
    chk_reg(5'd13, 32'h1237, "or_r13");
    chk_reg(5'd14, 32'h1, "slti_r14");
    chk_reg(5'd15, 32'd100, "addiu_r15");
    chk_reg(5'd16, 32'd103, "addu_r16");
    chk_reg(5'd31, 32'd64, "r31_final");
    chk_reg(5'd17, 32'h0, "r17_untouched");
    adv_to(102);
    check("loop_pc_odd", dut.PC, 32'd84);

    #10;
    rstn = 1'b0;
    #1;
    check("midrst_pc", dut.PC, 32'h0);
    chk_reg(5'd2, 32'h0, "midrst_r2");
    check("midrst_mem", dut.U_DM.dmem[64], 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
